writeback_lsu: RTL
==================

Name: writeback_lsu

Overview:
- Parametrised successor to the current writeback stage: owns the M->W pipeline register, the load-response capture buffer and load data extraction.
- Adds what the current stage lacks:
  - DATA_W generalisation to 32 or 64 bits, including doubleword loads.
  - MIPS LWL/LWR merge.
  - Tolerance of late dbus responses through a WAIT/HELD state machine.
  - Discard of responses that belong to flushed loads.
- Sits between the memory stage and the regfile and forwarding network.

Parameters:
- DATA_W, 32: datapath width, 32 or 64. Lane offset width is OFS_W = log2(DATA_W/8).
- ADDR_W, 32: PC width.
- REG_W, 5: register index width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- StallW, in, 1: hold the W register.
- FlushW, in, 1: W register becomes a bubble.
- ValidM, in, 1: M holds a real instruction.
- PCM, in, ADDR_W: PC in M.
- ALUOutM, in, DATA_W: ALU result or load address.
- WriteRegM, in, REG_W: destination register.
- RegWriteM, in, 1: instruction writes the regfile.
- MemtoRegM, in, 1: instruction is a load.
- SizeM, in, 2: 0=1B, 1=2B, 2=4B, 3=8B. Value 3 is legal only when DATA_W=64.
- SignedM, in, 1: sign-extend the loaded value.
- LModeM, in, 2: 0=normal, 1=LWL, 2=LWR. Honoured only when DATA_W=32.
- RtOldM, in, DATA_W: old rt value for LWL/LWR.
- DataOkW, in, 1: dbus response valid this cycle.
- DataW, in, DATA_W: dbus response data.
- PCW, out, ADDR_W: PC in W.
- ResultW, out, DATA_W: writeback data.
- WriteRegW, out, REG_W: writeback register.
- RegWriteW, out, 1: regfile write enable.
- WaitW, out, 1: load in W has no data yet; hazard unit must stall.

Behaviour:
- Reset (async, active-high):
  - W register becomes a bubble: valid=0, all fields 0.
  - State IDLE, drop=0, data buffer 0.
  - Outputs PCW=0, ResultW=0, WriteRegW=0, RegWriteW=0, WaitW=0.
  - Reset asserted mid-load abandons that load; no response is dropped after reset.
- W register update on the clk rising edge:
  - FlushW: W becomes a bubble. FlushW wins over StallW.
  - else StallW: hold.
  - else load all M fields.
- State machine for the instruction in W:
  - IDLE: W is a bubble or a non-load. WaitW=0.
  - WAIT: W holds a valid load and no data has been captured.
    - If DataOkW && !drop: data bypasses combinationally into ResultW that cycle, WaitW=0, RegWriteW=RegWrite. The data is also captured into the buffer.
    - If still stalled at the edge: go to HELD.
    - Otherwise WaitW=1 and RegWriteW=0.
  - HELD: data buffer valid; ResultW is taken from the buffer. WaitW=0. Any DataOkW is illegal and ignored.
  - Leaving W (W register loads or flushes): next state is WAIT if the new W is a valid load, else IDLE.
- Flushed-load response discard:
  - Flush while in WAIT and no DataOkW that cycle: set drop=1.
  - The next DataOkW clears drop and is discarded; it is never captured or bypassed.
  - A new load may enter W while drop=1. It stays WAIT through the discarded response and takes the following one.
- Data extraction:
  - ofs = ALUOutW[OFS_W-1:0].
  - Size n bytes: take DataW bytes [ofs .. ofs+n-1]. Offset bits below n are ignored, i.e. the offset is aligned down to n.
  - Zero- or sign-extend to DATA_W according to SignedW.
  - Size 4 with DATA_W=64 extends from bit 31.
  - Size 3 with DATA_W=32 is treated as size 2.
- LWL/LWR merge (DATA_W=32, little-endian, o = ALUOutW[1:0]):
  - LWL: result = (mem << 8*(3-o)) | (RtOldW & ((1 << 8*(3-o)) - 1)).
  - LWR: result = (mem >> 8*o) | (RtOldW & ~(0xFFFFFFFF >> 8*o)).
  - SizeW and SignedW are ignored in these modes.
- Result selection:
  - ResultW = MemtoRegW ? extracted value : ALUOutW.
  - RegWriteW = validW & RegWriteW_q & (!MemtoRegW | data available).
  - RegWriteW stays asserted on every held cycle; this is idempotent.
- Simultaneous DataOkW and FlushW in WAIT: data is discarded and drop stays 0, because the response has been consumed.

Test Plan:
- lb, offset 3, signed, DataW=0x80FF1234 -> ResultW=0xFFFFFF80, RegWriteW=1 in the same cycle data arrives.
- lhu, offset 2, DATA_W=64, DataW=0x1122334455668899 -> ResultW=0x5566; ld, offset 0 -> full 64-bit value.
- LWL, o=1, mem=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344. LWR, o=1 -> 0x11AABBCC.
- Load enters W, no DataOkW for 3 cycles -> WaitW=1 and RegWriteW=0 for those cycles. DataOkW arrives while StallW=1 -> HELD; ResultW stays stable for 2 more stall cycles.
- Load in WAIT, FlushW=1 -> next load enters. First DataOkW (0xDEAD) is dropped; second (0x0042) -> ResultW=0x42.
- Reset asserted mid-WAIT -> all outputs 0 asynchronously, state IDLE, drop=0.

Source files
------------

// File: rtl/writeback_lsu.sv
// M->W pipeline register, load response capture and load data extraction.
// Tolerates late dbus responses and discards responses owed to flushed loads.
module writeback_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic [ADDR_W-1:0] PCM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [1:0]        SizeM,
  input  logic              SignedM,
  input  logic [1:0]        LModeM,
  input  logic [DATA_W-1:0] RtOldM,
  input  logic              DataOkW,
  input  logic [DATA_W-1:0] DataW,
  output logic [ADDR_W-1:0] PCW,
  output logic [DATA_W-1:0] ResultW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              RegWriteW,
  output logic              WaitW
);

  localparam int OFS_W = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HELD
  } state_t;

  state_t state, state_n;
  logic drop, drop_n;
  logic [DATA_W-1:0] hold_data;

  logic              w_valid;
  logic [ADDR_W-1:0] w_pc;
  logic [DATA_W-1:0] w_alu;
  logic [REG_W-1:0]  w_reg;
  logic              w_rw;
  logic              w_load;
  logic [1:0]        w_size;
  logic              w_sgn;
  logic [1:0]        w_lmode;
  logic [DATA_W-1:0] w_rt;

  logic take;
  logic avail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushW) begin
      w_valid <= 1'b0;
      w_pc    <= '0;
      w_alu   <= '0;
      w_reg   <= '0;
      w_rw    <= 1'b0;
      w_load  <= 1'b0;
      w_size  <= '0;
      w_sgn   <= 1'b0;
      w_lmode <= '0;
      w_rt    <= '0;
    end else if (!StallW) begin
      w_valid <= ValidM;
      w_pc    <= PCM;
      w_alu   <= ALUOutM;
      w_reg   <= WriteRegM;
      w_rw    <= RegWriteM;
      w_load  <= MemtoRegM;
      w_size  <= SizeM;
      w_sgn   <= SignedM;
      w_lmode <= LModeM;
      w_rt    <= RtOldM;
    end
  end

  assign take  = (state == WAIT) && DataOkW && !drop;
  assign avail = take || (state == HELD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drop      <= 1'b0;
      hold_data <= '0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      if (take)
        hold_data <= DataW;
    end
  end

  always_comb begin
    state_n = state;
    drop_n  = drop;
    if (DataOkW && drop)
      drop_n = 1'b0;
    // A flushed load still owes us one response.
    if (state == WAIT && FlushW && !DataOkW)
      drop_n = 1'b1;
    if (FlushW)
      state_n = IDLE;
    else if (!StallW)
      state_n = (ValidM && MemtoRegM) ? WAIT : IDLE;
    else if (take)
      state_n = HELD;
  end

  logic [1:0]        sz;
  logic [OFS_W-1:0]  ofs;
  logic [OFS_W-1:0]  low;
  logic [OFS_W-1:0]  aofs;
  logic [DATA_W-1:0] mem;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;
  logic              sb;
  logic [DATA_W-1:0] ext;
  logic [4:0]        sl;
  logic [4:0]        sr;

  always_comb begin
    mem = (state == HELD) ? hold_data : DataW;
    sz  = w_size;
    if (DATA_W == 32 && sz == 2'd3)
      sz = 2'd2;
    case (sz)
      2'd0: begin
        mask = DATA_W'(8'hFF);
        low  = OFS_W'(3'd0);
      end
      2'd1: begin
        mask = DATA_W'(16'hFFFF);
        low  = OFS_W'(3'd1);
      end
      2'd2: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        low  = OFS_W'(3'd3);
      end
      default: begin
        mask = '1;
        low  = OFS_W'(3'd7);
      end
    endcase
    ofs  = w_alu[OFS_W-1:0];
    aofs = ofs & ~low;
    sh   = mem >> {aofs, 3'b000};
    sb   = |(sh & mask & ~(mask >> 1));
    ext  = (sh & mask) | ((w_sgn && sb) ? ~mask : '0);
    sl   = {~w_alu[1:0], 3'b000};
    sr   = {w_alu[1:0], 3'b000};
    if (DATA_W == 32 && w_lmode == 2'd1)
      ext = (mem << sl) | (w_rt & ~({DATA_W{1'b1}} << sl));
    else if (DATA_W == 32 && w_lmode == 2'd2)
      ext = (mem >> sr) | (w_rt & ~({DATA_W{1'b1}} >> sr));
  end

  assign PCW       = w_pc;
  assign WriteRegW = w_reg;
  assign ResultW   = w_load ? ext : w_alu;
  assign RegWriteW = w_valid && w_rw && (!w_load || avail);
  assign WaitW     = (state == WAIT) && !take;

endmodule
